// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: RV32I load/store funct3 codes and clear-FSM states.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extraction/extension and store byte-enables/lane replication.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] wd,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Halfword lane uses only lane[1], so an odd address is silently aligned down.
  always_comb begin
    sel_byte  = mem_word[{lane, 3'b000} +: 8];
    sel_half  = lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_data = mem_word;
      F3_BU:   load_data = {24'b0, sel_byte};
      F3_HU:   load_data = {16'b0, sel_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    byte_en    = 4'b0000;
    store_data = wd;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{wd[7:0]}};
      end
      F3_H: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wd[15:0]}};
      end
      F3_W: begin
        byte_en    = 4'b1111;
        store_data = wd;
      end
      default: byte_en = 4'b0000;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// RV32I data memory with a post-reset clear sequencer that holds busy until every word is zeroed.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  funct3,
  output logic [31:0] rd,
  output logic        busy,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  dmem_state_t   state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic          clear_we;
  logic [AW-1:0] widx;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [31:0]   store_data;
  logic          store_en;
  logic          unused_addr_bits;

  assign widx             = addr[AW+1:2];
  assign unused_addr_bits = ^addr[31:AW+2];
  assign busy             = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clear_we   = 1'b0;
    if (state == CLEAR) begin
      clear_we = 1'b1;
      ptr_next = ptr + 1'b1;
      if (ptr == AW'(DEPTH_WORDS - 1)) state_next = READY;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = (we | re) & ~busy &
                    (((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3 == F3_W) & (addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .funct3     (funct3),
    .lane       (addr[1:0]),
    .mem_word   (mem[widx]),
    .wd         (wd),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .store_data (store_data)
  );

  assign store_en = we & ~busy & ~misalign & ~rst;
  assign rd       = (re & ~busy & ~misalign) ? load_data : '0;

  // Clearing takes priority; stores are already blocked while busy.
  always_ff @(posedge clk) begin
    if (clear_we && !rst) begin
      mem[ptr] <= '0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[widx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: byte-array reference model, directed cases plus random traffic.
module tb_data_memory;

  localparam int DEPTH  = 1024;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rd;
  logic        busy;
  logic        misalign;

  data_memory #(.DEPTH_WORDS(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wd       (wd),
    .we       (we),
    .re       (re),
    .funct3   (funct3),
    .rd       (rd),
    .busy     (busy),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        busy;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [NBYTES];
  int         clear_cycles = 0;

  function automatic int bidx(input logic [31:0] a);
    return int'(a % 32'(NBYTES));
  endfunction

  function automatic logic ref_is_mis(input logic [31:0] a, input logic [2:0] f3,
                                      input logic w, input logic r, input logic bsy);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((w || r) && !bsy) begin
      if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
      if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] hb, wb;
    logic [7:0]  b;
    logic [15:0] h;
    hb = a & ~32'd1;
    wb = a & ~32'd3;
    b  = ref_mem[bidx(a)];
    h  = {ref_mem[bidx(hb + 1)], ref_mem[bidx(hb)]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {ref_mem[bidx(wb + 3)], ref_mem[bidx(wb + 2)],
                       ref_mem[bidx(wb + 1)], ref_mem[bidx(wb)]};
      3'd4:    return {24'b0, b};
      3'd5:    return {16'b0, h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] hb, wb;
    hb = a & ~32'd1;
    wb = a & ~32'd3;
    case (f3)
      3'd0: ref_mem[bidx(a)] = d[7:0];
      3'd1: begin
        ref_mem[bidx(hb)]     = d[7:0];
        ref_mem[bidx(hb + 1)] = d[15:8];
      end
      3'd2: for (int i = 0; i < 4; i++) ref_mem[bidx(wb + 32'(i))] = d[8*i +: 8];
      default: ;
    endcase
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    clear_cycles = 0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic r, input logic [2:0] f3, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    addr   = a;
    wd     = d;
    we     = w;
    re     = r;
    funct3 = f3;
    e.busy = (clear_cycles < DEPTH);
    e.mis  = ref_is_mis(a, f3, w, r, e.busy);
    e.rd   = (r && !e.busy && !e.mis) ? ref_load(a, f3) : 32'd0;
    e.tag  = tag;
    exp_q.push_back(e);
    if (w && !e.busy && !e.mis) ref_store(a, d, f3);
    if (clear_cycles < DEPTH) clear_cycles++;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (rd !== e.rd || busy !== e.busy || misalign !== e.mis) begin
      errors++;
      $display("[TB] FAIL %s: rd=%h exp=%h busy=%b exp=%b misalign=%b exp=%b",
               e.tag, rd, e.rd, busy, e.busy, misalign, e.mis);
    end
  endtask

  // Monitor: DUT outputs are combinational, so each queued expectation is due mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset();

    for (int i = 0; i < DEPTH; i++)
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1,
                    3'($urandom_range(0, 7)), "clear_busy");

    applyStimulus(32'h0000_0000, 32'h0, 1'b0, 1'b1, 3'd2, "lw_0_after_clear");
    applyStimulus(32'h0000_0FFC, 32'h0, 1'b0, 1'b1, 3'd2, "lw_ffc_after_clear");

    applyStimulus(32'h0000_0010, 32'h80F1_2345, 1'b1, 1'b0, 3'd2, "sw_10");
    applyStimulus(32'h0000_0010, 32'h0, 1'b0, 1'b1, 3'd0, "lb_10");
    applyStimulus(32'h0000_0013, 32'h0, 1'b0, 1'b1, 3'd0, "lb_13");
    applyStimulus(32'h0000_0013, 32'h0, 1'b0, 1'b1, 3'd4, "lbu_13");
    applyStimulus(32'h0000_0012, 32'h0, 1'b0, 1'b1, 3'd1, "lh_12");
    applyStimulus(32'h0000_0012, 32'h0, 1'b0, 1'b1, 3'd5, "lhu_12");
    applyStimulus(32'h0000_0010, 32'h0, 1'b0, 1'b1, 3'd3, "illegal_f3_load");

    applyStimulus(32'h0000_0020, 32'h1122_3344, 1'b1, 1'b0, 3'd2, "sw_20");
    applyStimulus(32'h0000_0021, 32'h1234_56AA, 1'b1, 1'b0, 3'd0, "sb_21");
    applyStimulus(32'h0000_0020, 32'h0, 1'b0, 1'b1, 3'd2, "lw_20_after_sb");
    applyStimulus(32'h0000_0022, 32'h5555_BEEF, 1'b1, 1'b0, 3'd1, "sh_22");
    applyStimulus(32'h0000_0020, 32'h0, 1'b0, 1'b1, 3'd2, "lw_20_after_sh");
    applyStimulus(32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd6, "illegal_f3_store");
    applyStimulus(32'h0000_0020, 32'h0, 1'b0, 1'b1, 3'd2, "lw_20_unchanged");

    applyStimulus(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd2, "sw_1000_wrap");
    applyStimulus(32'h0000_0000, 32'h0, 1'b0, 1'b1, 3'd2, "lw_0_wrapped");

    applyStimulus(32'h0000_0040, 32'hCAFE_F00D, 1'b1, 1'b0, 3'd2, "sw_40");
    applyStimulus(32'h0000_0040, 32'h0102_0304, 1'b1, 1'b1, 3'd2, "sw_lw_same_cycle");
    applyStimulus(32'h0000_0040, 32'h0, 1'b0, 1'b1, 3'd2, "lw_40_new_data");

    applyStimulus(32'h0000_0030, 32'h7766_5544, 1'b1, 1'b0, 3'd2, "sw_30");
    applyStimulus(32'h0000_0031, 32'h0000_1234, 1'b1, 1'b0, 3'd1, "sh_31_misaligned");
    applyStimulus(32'h0000_0030, 32'h0, 1'b0, 1'b1, 3'd2, "lw_30_after_sh31");
    applyStimulus(32'h0000_0032, 32'h0, 1'b0, 1'b1, 3'd2, "lw_32_misaligned");

    for (int i = 0; i < 1500; i++)
      applyStimulus((32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 63)),
                    $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), "random");

    applyReset();
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom, $urandom, 1'b0, 1'b1, 3'd2, "clear_before_rereset");
    applyReset();
    applyStimulus(32'h0000_0050, 32'h1234_5678, 1'b1, 1'b0, 3'd2, "sw_50_while_busy");
    for (int i = 1; i < DEPTH; i++)
      applyStimulus($urandom, 32'h0, 1'b0, 1'b1, 3'd2, "clear_after_rereset");
    applyStimulus(32'h0000_0050, 32'h0, 1'b0, 1'b1, 3'd2, "lw_50_store_lost");

    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory downstream of the ALU in the single-cycle RISC-V core. It takes the ALU result as a byte address and performs RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW), returning sign- or zero-extended load data to the writeback mux. After every reset, a clear sequencer zeroes the whole array one word per cycle and asserts `busy` so the core stalls until the memory is ready.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words. Must be a power of two, at least 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `addr`  in  32: byte address (ALU result).
- `wd`  in  32: store data (rs2 value).
- `we`  in  1: store request.
- `re`  in  1: load request.
- `funct3`  in  3: access size and signedness, RV32I encoding.
- `rd`  out  32: load data, extended.
- `busy`  out  1: clear sequence in progress; the core must stall.
- `misalign`  out  1: current request is misaligned (see Configuration).

## Operation
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so accesses wrap modulo the array size.
- Byte lanes are little-endian. The lane is selected by `addr[1:0]`.
- Loads, selected by `funct3`:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half (lane `addr[1]`).
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extend.
  - Any other code: `rd`=0.
- Stores, selected by `funct3`:
  - 000: write 1 byte, `wd[7:0]`, to the addressed lane.
  - 001: write 2 bytes, `wd[15:0]`, to half `addr[1]`.
  - 010: write the full word.
  - Other codes: no write.
- `rd`=0 when `re`=0 or `busy`=1.
- Clear FSM states are CLEAR and READY, with pointer `ptr` of width log2(DEPTH_WORDS).
  - While `rst`=1: state←CLEAR, `ptr`←0, no array write.
  - In CLEAR with `rst`=0: mem[`ptr`]←0 and `ptr`←`ptr`+1. When `ptr`=DEPTH_WORDS-1, that final word is written and the state goes to READY.
  - In READY: the FSM stays in READY until the next reset.
- `busy` = (state==CLEAR). While `busy`, `we` and `re` are ignored.
- `rst` asserted mid-clear restarts the sequence from `ptr`=0.

## Timing
- Reset values: `busy`=1, `rd`=0, `misalign`=0.
- Clear latency is DEPTH_WORDS cycles after `rst` falls. `busy` is low in cycle DEPTH_WORDS counted from the first cycle with `rst`=0 (cycle 0).
- Loads are combinational. `rd` is valid in the same cycle as `addr`/`re`.
- A store commits at the rising edge when `we`=1, `busy`=0, and the access is legal.
- `we` and `re` asserted together in the same cycle: the write commits at the edge, and `rd` shows the pre-write contents during that cycle. A load in the next cycle sees the new data.
- No other internal pipeline. Nothing is buffered between requests.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - `misalign` = (`we`|`re`) & !`busy` & ((half & `addr[0]`) | (word & `addr[1:0]`≠0)).
  - A misaligned store does not write.
  - A misaligned load returns `rd`=0.
- Undefined:
  - `misalign` is tied to 0.
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`. The access is performed at the aligned-down address.

## Structure
- Package `dmem_pkg` holds:
  - `funct3` constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Clear-FSM state enum `dmem_state_t` {CLEAR, READY}.
- Sub-module `dmem_lane_align` (combinational) does two jobs:
  - Load side: byte/half extraction and extension.
  - Store side: 4-bit byte-enable generation and write-data lane replication.
- The top level holds the array, the clear FSM and the gating logic.

## Test plan
- Reset 1 cycle, then release:
  - `busy`=1 for exactly 1024 cycles, then 0.
  - LW of addr 0x0 and 0xFFC returns 0x00000000.
- SW 0x80F1_2345 to 0x10, then LB 0x10 → 0x00000045.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80F1.
  - LHU 0x12 → 0x000080F1.
- SB 0xAA to 0x21 over an existing word 0x11223344 at 0x20 → LW 0x20 = 0x1122AA44.
  - SH 0xBEEF to 0x22 → LW 0x20 = 0xBEEFAA44.
- SW 0xDEADBEEF to 0x1000 (wraps to word 0), then LW 0x0 → 0xDEADBEEF.
- Reset asserted at clear cycle 500:
  - `busy` stays high for a further 1024 cycles after release.
  - A store attempted while `busy` is lost.
- With the macro defined: SH to 0x31 → `misalign`=1 and memory unchanged; LW 0x32 → `misalign`=1 and `rd`=0.
  - With the macro undefined: the same SH writes half 0 at 0x30.
